// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size and the
// default reset/trap vectors also used by the trap logic.
package if_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: owns the architectural PC, drives the instruction
// memory address and handles stall, EX redirect, misaligned-target trap and halt.
module if_pc_gen
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   output logic [31:0] o_addr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid,
   output logic        o_flush,
   output logic        o_misalign,
   output logic [31:0] o_fetch_cnt
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  cnt_q;
   logic         misalign_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VEC;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               // Halt beats redirect, redirect beats back-pressure.
               if (i_halt) begin
                  state_q <= HALT;
               end else if (i_redirect) begin
                  if (is_aligned(i_redirect_pc)) begin
                     pc_q <= i_redirect_pc;
                  end else begin
                     pc_q       <= TRAP_VEC;
                     misalign_q <= 1'b1;
                  end
               end else if (i_ready) begin
                  pc_q  <= pc_q + 32'(INSTR_BYTES);
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            HALT:    state_q <= HALT;
            default: state_q <= BOOT;
         endcase
      end
   end

   assign o_addr      = pc_q;
   assign o_pc        = pc_q;
   assign o_pc_plus4  = pc_q + 32'(INSTR_BYTES);
   assign o_valid     = (state_q == RUN);
   // Only path from inputs to outputs: the IF/ID bubble request for a taken redirect.
   assign o_flush     = i_redirect & (state_q == RUN);
   assign o_misalign  = misalign_q;
   assign o_fetch_cnt = cnt_q;

endmodule
